// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: default geometry and the
// Gray/binary conversion helpers used by both the read and write sides.
package fifo_pkg;

  // Default word width (one TX block) and address width (depth 32).
  localparam int FIFO_DATASIZE = 264;
  localparam int FIFO_ADDRSIZE = 5;

  // The helpers work on a 32-bit container. Zero-extending a narrower
  // pointer leaves its conversion unchanged, so any width up to 32 is
  // handled by size-casting the argument in and the result back out.
  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bundle: pointers and memory port towards the FIFO core,
// plus the first-word-fall-through valid/ready output stream.
interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE,
  parameter int ADDRSIZE = FIFO_ADDRSIZE
);

  logic [ADDRSIZE:0]   wptr;        // Gray write pointer, write-clock domain
  logic [DATASIZE-1:0] rdata;       // combinational mem[raddr]
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;        // Gray read pointer for the write side
  logic                rempty;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;
  logic [ADDRSIZE:0]   rlevel;

  // The read controller drives the pointer/status/stream side.
  modport master (
    input  wptr, rdata, dout_ready,
    output raddr, rptr, rempty, dout, dout_valid, rlevel
  );

  // The surrounding memory, write side and downstream consumer.
  modport slave (
    output wptr, rdata, dout_ready,
    input  raddr, rptr, rempty, dout, dout_valid, rlevel
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for multi-bit Gray pointers crossing clock domains.
// The input goes straight into the first flop with no logic in front of it.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q1_q;
  logic [WIDTH-1:0] q2_q;

  // Shift the asynchronous input through two stages.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      q1_q <= d_i;
      q2_q <= q1_q;
    end
  end

  assign q_o = q2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the PCS TX dual-clock FIFO. Keeps the read
// pointer and empty flag, and prefetches one word into an output register
// so downstream sees a first-word-fall-through valid/ready stream.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE,
  parameter int ADDRSIZE = FIFO_ADDRSIZE
) (
  input  logic           clk_i,
  input  logic           srst_i,
  fifo_rd_ctrl_if.master bus
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0]       rq2_wptr;
  logic [PW-1:0]       rbin_q,       rbin_d;
  logic [PW-1:0]       rptr_q,       rptr_d;
  logic                rempty_q,     rempty_d;
  logic [DATASIZE-1:0] dout_q,       dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic [PW-1:0]       rlevel_q,     rlevel_d;
  logic                rinc;

  sync_2ff #(.WIDTH(PW)) u_wptr_sync (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .d_i    (bus.wptr),
    .q_o    (rq2_wptr)
  );

  // Next-state: read when memory holds data and the output slot is free or
  // being drained this cycle; empty/level are judged against the next pointer.
  always_comb begin
    rinc         = !rempty_q && (!dout_valid_q || bus.dout_ready);
    rbin_d       = rbin_q + {{(PW-1){1'b0}}, rinc};
    rptr_d       = PW'(bin2gray(GRAY_MAX_W'(rbin_d)));
    rempty_d     = (rptr_d == rq2_wptr);
    rlevel_d     = PW'(gray2bin(GRAY_MAX_W'(rq2_wptr))) - rbin_d;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (rinc) begin
      // Refill, possibly in the same cycle the old word is accepted.
      dout_d       = bus.rdata;
      dout_valid_d = 1'b1;
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      rlevel_q     <= '0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rempty_q     <= rempty_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      rlevel_q     <= rlevel_d;
    end
  end

  assign bus.raddr      = rbin_q[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.rempty     = rempty_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.rlevel     = rlevel_q;

endmodule
